// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// the bit-counter width helper.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must hold 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        int r;
        r = $clog2(w);
        if (r < 1) begin
            r = 1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full adder, purely combinational. The serial controller reuses
// one instance of this cell for every bit position.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic s
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : fa_cell

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller. One full-adder cell is stepped over WIDTH
// cycles, LSB first. Operands are captured on an accepted start, so later
// changes on a/b/cin do not disturb an addition in progress. Results stay
// on sum/cout/ovf until the next accepted start begins shifting.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1'b1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;

    logic             cell_sum_s;
    logic             cell_carry_s;

    fa_cell u_fa_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .cout (cell_carry_s),
        .s    (cell_sum_s)
    );

    // Controller FSM: captures operands, steps the cell once per RUN cycle,
    // latches the flags on the last bit and emits the one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= {CW{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q     <= {1'b0, a_q[WIDTH-1:1]};
                    b_q     <= {1'b0, b_q[WIDTH-1:1]};
                    sum_q   <= {cell_sum_s, sum_q[WIDTH-1:1]};
                    carry_q <= cell_carry_s;
                    cnt_q   <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        // carry_q here is the carry into the sign bit
                        cout_q  <= cell_carry_s;
                        ovf_q   <= carry_q ^ cell_carry_s;
                        state_q <= DONE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks;
    int n_fail;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait up to 20 cycles for done; returns cycles waited and busy-high cycles seen before it.
    task automatic wait_done(output int lat, output int busy_cnt, output bit seen);
        lat = 0;
        seen = 1'b0;
        busy_cnt = busy ? 1 : 0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) seen = 1'b1;
            else if (busy) busy_cnt++;
        end
    endtask

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                         input string tag, input bit full);
        logic [8:0] exp_full;
        int         s_signed;
        logic       exp_ovf;
        int         lat;
        int         bc;
        bit         seen;
        exp_full = {1'b0, av} + {1'b0, bv} + {8'd0, ci};
        s_signed = int'($signed(av)) + int'($signed(bv)) + int'(ci);
        exp_ovf  = (s_signed > 127) || (s_signed < -128);
        @(negedge clk);
        a = av; b = bv; cin = ci; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~av; b = bv ^ 8'h5A; cin = ~ci;
        wait_done(lat, bc, seen);
        if (!seen) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            if (full) begin
                check_eq({tag, "_latency"}, lat, 32'd9);
                check_eq({tag, "_busy_cycles"}, bc, 32'd9);
                check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
            end
            check_eq({tag, "_sum"}, {24'd0, sum}, {24'd0, exp_full[7:0]});
            check_eq({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_full[8]});
            check_eq({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
            if (full) begin
                @(posedge clk);
                #1;
                check_eq({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
                check_eq({tag, "_sum_hold"}, {24'd0, sum}, {24'd0, exp_full[7:0]});
            end
        end
    endtask

    initial begin
        int  lat;
        int  bc;
        bit  seen;
        int  done_cnt;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b1;

        // reset with start high: start must not be accepted
        @(posedge clk); @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_sum", {24'd0, sum}, 32'd0);
        check_eq("rst_cout", {31'd0, cout}, 32'd0);
        check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); @(posedge clk);
        #1;
        check_eq("idle_hold_busy", {31'd0, busy}, 32'd0);
        check_eq("idle_hold_sum", {24'd0, sum}, 32'd0);

        // directed vectors
        do_op(8'hFF, 8'h01, 1'b0, "ff_p_01", 1'b1);
        do_op(8'h7F, 8'h01, 1'b0, "7f_p_01", 1'b1);
        do_op(8'h80, 8'h80, 1'b1, "80_p_80_c", 1'b1);
        do_op(8'h00, 8'h00, 1'b1, "00_p_00_c", 1'b1);

        // start held high through RUN: first result intact, second accepted right after done
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'hFF; b = 8'hFF;
        wait_done(lat, bc, seen);
        check_eq("b2b_first_seen", {31'd0, seen}, 32'd1);
        check_eq("b2b_first_latency", lat, 32'd9);
        check_eq("b2b_first_sum", {24'd0, sum}, 32'h46);
        check_eq("b2b_first_cout", {31'd0, cout}, 32'd0);
        check_eq("b2b_idle_at_done", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("b2b_second_accepted", {31'd0, busy}, 32'd1);
        wait_done(lat, bc, seen);
        check_eq("b2b_second_latency", lat, 32'd9);
        check_eq("b2b_second_sum", {24'd0, sum}, 32'hFE);
        check_eq("b2b_second_cout", {31'd0, cout}, 32'd1);
        check_eq("b2b_second_ovf", {31'd0, ovf}, 32'd0);

        // reset during RUN aborts with no done pulse
        do_op(8'h80, 8'h80, 1'b1, "pre_abort", 1'b0);
        @(negedge clk);
        a = 8'h55; b = 8'hAA; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_sum", {24'd0, sum}, 32'd0);
        check_eq("abort_cout", {31'd0, cout}, 32'd0);
        check_eq("abort_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check_eq("abort_no_done", done_cnt, 32'd0);
        do_op(8'h0F, 8'h01, 1'b0, "after_abort", 1'b1);

        // random operations against the arithmetic reference
        for (int i = 0; i < 1000; i++) begin
            do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), "rand", 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_add_ctrl
